// File: rtl/mem_port_arbiter.sv
// Two-requester (I-refill / D-mem) arbiter onto one external memory port, with bus-hang watchdog.
// Fixed D-side priority by default; define ARVI_ARB_ROUND_ROBIN_EN for round-robin on contention.
`ifndef XLEN
`define XLEN 32
`endif

module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int XLEN           = `XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_IC_DataReq,
  input  logic [XLEN-1:0] i_IC_Addr,
  output logic [XLEN-1:0] o_IC_Data,
  output logic            o_IC_MemReady,
  input  logic            i_DM_MemRead,
  input  logic            i_DM_Wen,
  input  logic [XLEN-1:0] i_DM_Addr,
  input  logic [XLEN-1:0] i_DM_Wd,
  input  logic [3:0]      i_DM_byte_en,
  output logic [XLEN-1:0] o_DM_ReadData,
  output logic            o_DM_data_ready,
  output logic            o_MEM_req,
  output logic            o_MEM_wen,
  output logic [XLEN-1:0] o_MEM_addr,
  output logic [XLEN-1:0] o_MEM_wdata,
  output logic [3:0]      o_MEM_byte_en,
  input  logic [XLEN-1:0] i_MEM_rdata,
  input  logic            i_MEM_ready,
  output logic            o_busy,
  output logic            o_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WD_LAST = WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_owner_dm;
  logic              r_mem_req;
  logic              r_mem_wen;
  logic [XLEN-1:0]   r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;
  logic [3:0]        r_mem_be;
  logic [XLEN-1:0]   r_ic_data;
  logic [XLEN-1:0]   r_dm_data;
  logic              r_ic_rdy;
  logic              r_dm_rdy;
  logic              r_busy;
  logic              r_timeout;
  logic [31:0]       r_wdog_cnt;

  logic              w_dm_pend;
  logic              w_ic_pend;
  logic              w_any_pend;
  logic              w_grant_dm;
  logic              w_wdog_exp;
  logic              w_bus_done;
  logic [XLEN-1:0]   w_resp_data;

  assign w_dm_pend  = i_DM_MemRead | i_DM_Wen;
  assign w_ic_pend  = i_IC_DataReq;
  assign w_any_pend = w_dm_pend | w_ic_pend;

`ifdef ARVI_ARB_ROUND_ROBIN_EN
  // Records whether the I-side took the most recent grant; resets pointing at the I-side.
  logic r_last_ic;

  assign w_grant_dm = w_dm_pend & (~w_ic_pend | r_last_ic);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_ic <= 1'b1;
    end else if (r_state == S_IDLE && w_any_pend) begin
      r_last_ic <= ~w_grant_dm;
    end
  end
`else
  assign w_grant_dm = w_dm_pend;
`endif

  // A ready in the expiry cycle is a normal completion, so it masks the abort.
  assign w_wdog_exp  = WD_EN && (r_wdog_cnt == WD_LAST) && !i_MEM_ready;
  assign w_bus_done  = i_MEM_ready | w_wdog_exp;
  assign w_resp_data = i_MEM_ready ? i_MEM_rdata : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_pend) w_state_nxt = S_BUS;
      S_BUS:   if (w_bus_done) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner_dm  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= 4'h0;
      r_ic_data   <= '0;
      r_dm_data   <= '0;
      r_ic_rdy    <= 1'b0;
      r_dm_rdy    <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_wdog_cnt  <= '0;
    end else begin
      r_ic_rdy <= 1'b0;
      r_dm_rdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_pend) begin
            r_owner_dm <= w_grant_dm;
            r_mem_req  <= 1'b1;
            r_busy     <= 1'b1;
            r_wdog_cnt <= '0;
            if (w_grant_dm) begin
              r_mem_wen   <= i_DM_Wen;
              r_mem_addr  <= i_DM_Addr;
              r_mem_wdata <= i_DM_Wd;
              r_mem_be    <= i_DM_byte_en;
            end else begin
              r_mem_wen   <= 1'b0;
              r_mem_addr  <= i_IC_Addr;
              r_mem_wdata <= '0;
              r_mem_be    <= 4'hF;
            end
          end
        end
        S_BUS: begin
          r_wdog_cnt <= r_wdog_cnt + 32'd1;
          if (w_bus_done) begin
            r_mem_req <= 1'b0;
            if (w_wdog_exp) r_timeout <= 1'b1;
            if (r_owner_dm) begin
              r_dm_data <= w_resp_data;
              r_dm_rdy  <= 1'b1;
            end else begin
              r_ic_data <= w_resp_data;
              r_ic_rdy  <= 1'b1;
            end
          end
        end
        S_RESP: r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_IC_Data       = r_ic_data;
  assign o_IC_MemReady   = r_ic_rdy;
  assign o_DM_ReadData   = r_dm_data;
  assign o_DM_data_ready = r_dm_rdy;
  assign o_MEM_req       = r_mem_req;
  assign o_MEM_wen       = r_mem_wen;
  assign o_MEM_addr      = r_mem_addr;
  assign o_MEM_wdata     = r_mem_wdata;
  assign o_MEM_byte_en   = r_mem_be;
  assign o_busy          = r_busy;
  assign o_timeout       = r_timeout;

endmodule
